// File: rtl/mem_bridge.sv
// CPU data-bus to word-memory bridge: lane steering, alignment checks, one outstanding access.
// Optional ACCESS watchdog enabled by defining MEM_BRIDGE_TIMEOUT_EN.

`ifndef MEM_ACCESS
`define MEM_ACCESS logic [1:0]
`endif
`ifndef MEM_LEN
`define MEM_LEN logic [1:0]
`endif

module mem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic [31:0] db_addr,
    input  `MEM_ACCESS  db_accessType,
    input  `MEM_LEN     db_memLen,
    input  logic [31:0] db_dataOut,
    output logic [31:0] db_dataIn,
    output logic        db_ready,
    output logic        db_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_W    = 2'd2;
    localparam logic [1:0] LEN_B    = 2'd0;
    localparam logic [1:0] LEN_H    = 2'd1;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("mem_bridge: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  lane, lane_nxt;
    logic [1:0]  len, len_nxt;
    logic        write, write_nxt;
    logic        req_nxt, we_nxt, ready_nxt, error_nxt;
    logic [29:0] addr_nxt;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt, rdata_nxt;

    logic        misaligned_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [4:0]  shamt_c;
    logic [15:0] rd_shift_c;
    logic [31:0] rd_c;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic [7:0]  cnt, cnt_nxt, cnt_inc;
    assign cnt_inc = cnt + 8'd1;
`endif

    // Request decode from the live CPU inputs (only consumed in IDLE)
    always_comb begin
        misaligned_c = 1'b0;
        be_c         = 4'b1111;
        wdata_c      = db_dataOut;
        case (db_memLen)
            LEN_B: begin
                be_c    = 4'(4'b0001 << db_addr[1:0]);
                wdata_c = {4{db_dataOut[7:0]}};
            end
            LEN_H: begin
                misaligned_c = db_addr[0];
                be_c         = db_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c      = {2{db_dataOut[15:0]}};
            end
            default: misaligned_c = (db_addr[1:0] != 2'b00);
        endcase
    end

    // Read lane extraction from the captured byte offset and size
    always_comb begin
        case (len)
            LEN_B:   shamt_c = {lane, 3'b000};
            LEN_H:   shamt_c = {lane[1], 4'b0000};
            default: shamt_c = 5'd0;
        endcase
        rd_shift_c = 16'(mem_rdata >> shamt_c);
        case (len)
            LEN_B:   rd_c = {24'd0, rd_shift_c[7:0]};
            LEN_H:   rd_c = {16'd0, rd_shift_c};
            default: rd_c = mem_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        lane_nxt  = lane;
        len_nxt   = len;
        write_nxt = write;
        req_nxt   = mem_req;
        we_nxt    = mem_we;
        addr_nxt  = mem_addr;
        be_nxt    = mem_be;
        wdata_nxt = mem_wdata;
        rdata_nxt = db_dataIn;
        ready_nxt = 1'b0;
        error_nxt = 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        cnt_nxt   = cnt;
`endif
        case (state)
            IDLE: begin
                if (db_accessType != ACC_NONE) begin
                    lane_nxt  = db_addr[1:0];
                    len_nxt   = db_memLen;
                    write_nxt = (db_accessType == ACC_W);
                    if (misaligned_c) begin
                        state_nxt = RESP;
                        ready_nxt = 1'b1;
                        error_nxt = 1'b1;
                        rdata_nxt = 32'd0;
                    end else begin
                        state_nxt = ACCESS;
                        req_nxt   = 1'b1;
                        we_nxt    = (db_accessType == ACC_W);
                        addr_nxt  = db_addr[31:2];
                        be_nxt    = be_c;
                        wdata_nxt = wdata_c;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                        cnt_nxt   = 8'd0;
`endif
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_nxt = RESP;
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    ready_nxt = 1'b1;
                    if (!write) begin
                        rdata_nxt = rd_c;
                    end
`ifdef MEM_BRIDGE_TIMEOUT_EN
                end else if (cnt_inc == 8'(TIMEOUT)) begin
                    // An ack in the same cycle takes the branch above instead
                    state_nxt = RESP;
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    ready_nxt = 1'b1;
                    error_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
`endif
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= IDLE;
            lane      <= 2'd0;
            len       <= 2'd0;
            write     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 30'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            db_dataIn <= 32'd0;
            db_ready  <= 1'b0;
            db_error  <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            cnt       <= 8'd0;
`endif
        end else begin
            state     <= state_nxt;
            lane      <= lane_nxt;
            len       <= len_nxt;
            write     <= write_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_be    <= be_nxt;
            mem_wdata <= wdata_nxt;
            db_dataIn <= rdata_nxt;
            db_ready  <= ready_nxt;
            db_error  <= error_nxt;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            cnt       <= cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed cases plus random transfers against a byte-level model.
// Define MEM_BRIDGE_TIMEOUT_EN to exercise the watchdog with TIMEOUT=4.

module tb_mem_bridge;

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_R    = 2'd1;
    localparam logic [1:0] ACC_W    = 2'd2;
    localparam logic [1:0] ACC_X    = 2'd3;
    localparam logic [1:0] LEN_B    = 2'd0;
    localparam logic [1:0] LEN_H    = 2'd1;
    localparam logic [1:0] LEN_W    = 2'd2;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        clk;
    logic        res_n;
    logic [31:0] db_addr;
    logic [1:0]  db_accessType;
    logic [1:0]  db_memLen;
    logic [31:0] db_dataOut;
    logic [31:0] db_dataIn;
    logic        db_ready;
    logic        db_error;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd = 32'd0;

    mem_bridge #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk           (clk),
        .res_n         (res_n),
        .db_addr       (db_addr),
        .db_accessType (db_accessType),
        .db_memLen     (db_memLen),
        .db_dataOut    (db_dataOut),
        .db_dataIn     (db_dataIn),
        .db_ready      (db_ready),
        .db_error      (db_error),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-level reference: size in bytes, covered lanes, replicated data, extracted read data
    function automatic int nbytes(input logic [1:0] len);
        return (len == LEN_B) ? 1 : (len == LEN_H) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] len);
        int unsigned m;
        m = ((32'd1 << nbytes(len)) - 1) << (a % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] len);
        logic [31:0] w;
        int n;
        n = nbytes(len);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] a, input logic [1:0] len, input logic [31:0] r);
        longint unsigned v, mask;
        mask = (64'd1 << (8 * nbytes(len))) - 1;
        v = (64'(r) >> (8 * (a % 4))) & mask;
        return 32'(v);
    endfunction

    task automatic run_txn(input logic [31:0] a, input logic [1:0] len, input logic [1:0] typ,
                           input logic [31:0] d, input logic [31:0] r, input int waits);
        bit wr;
        bit mis;
        wr  = (typ == ACC_W);
        mis = (a % nbytes(len)) != 0;
        @(negedge clk);
        db_addr = a; db_memLen = len; db_accessType = typ; db_dataOut = d;
        @(posedge clk); #1;
        db_accessType = ACC_NONE; db_addr = $urandom; db_dataOut = $urandom;
        db_memLen = 2'($urandom_range(0, 2));
        if (mis) begin
            check("mis_req", 32'(mem_req), 32'd0);
            check("mis_ready", 32'(db_ready), 32'd1);
            check("mis_error", 32'(db_error), 32'd1);
            check("mis_dataIn", db_dataIn, 32'd0);
            last_rd = 32'd0;
            @(posedge clk); #1;
            check("mis_ready_pulse", 32'(db_ready), 32'd0);
        end else begin
            check("req", 32'(mem_req), 32'd1);
            check("we", 32'(mem_we), 32'(wr));
            check("addr", 32'(mem_addr), 32'(a[31:2]));
            check("be", 32'(mem_be), 32'(m_be(a, len)));
            if (wr) check("wdata", mem_wdata, m_wdata(d, len));
            check("ready_early", 32'(db_ready), 32'd0);
            for (int w = 0; w < waits; w++) begin
                @(negedge clk);
                mem_ack = 1'b0;
                db_accessType = 2'($urandom_range(1, 3));
                db_addr = $urandom;
                @(posedge clk); #1;
                check("req_hold", 32'(mem_req), 32'd1);
                check("be_hold", 32'(mem_be), 32'(m_be(a, len)));
                check("ready_wait", 32'(db_ready), 32'd0);
            end
            @(negedge clk);
            mem_ack = 1'b1; mem_rdata = r; db_accessType = ACC_NONE;
            @(posedge clk); #1;
            mem_rdata = $urandom;
            if (!wr) last_rd = m_rd(a, len, r);
            check("ack_req", 32'(mem_req), 32'd0);
            check("ack_ready", 32'(db_ready), 32'd1);
            check("ack_error", 32'(db_error), 32'd0);
            check("dataIn", db_dataIn, last_rd);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            check("ready_pulse", 32'(db_ready), 32'd0);
            check("req_after", 32'(mem_req), 32'd0);
            check("dataIn_hold", db_dataIn, last_rd);
        end
    endtask

    task automatic idle_gap();
        @(negedge clk);
        mem_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check("idle_req", 32'(mem_req), 32'd0);
        check("idle_ready", 32'(db_ready), 32'd0);
        mem_ack = 1'b0;
    endtask

    initial begin
        int bad;
        res_n = 1'b0; db_addr = 32'd0; db_accessType = ACC_NONE; db_memLen = LEN_B;
        db_dataOut = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        #12;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_ready", 32'(db_ready), 32'd0);
        check("rst_error", 32'(db_error), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_dataIn", db_dataIn, 32'd0);
        @(negedge clk); res_n = 1'b1;

        run_txn(32'h8000_0003, LEN_B, ACC_R, 32'd0, 32'hAABB_CCDD, 0);
        run_txn(32'h8000_0102, LEN_H, ACC_W, 32'h0000_1234, 32'd0, 3);
        run_txn(32'h8000_0002, LEN_W, ACC_R, 32'd0, 32'd0, 0);
        run_txn(32'h8000_0001, LEN_H, ACC_X, 32'd0, 32'd0, 0);
        run_txn(32'h8000_0006, LEN_H, ACC_R, 32'd0, 32'h8765_4321, 1);

        for (int i = 0; i < 60; i++) begin
            run_txn($urandom, 2'($urandom_range(0, 2)), 2'($urandom_range(1, 3)),
                    $urandom, $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle_gap();
        end

        // Reset in the middle of an access abandons it
        @(negedge clk);
        db_addr = 32'h8000_0010; db_memLen = LEN_W; db_accessType = ACC_R;
        @(posedge clk); #1;
        db_accessType = ACC_NONE;
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #2 res_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_be", 32'(mem_be), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_dataIn", db_dataIn, 32'd0);
        check("mid_rst_ready", 32'(db_ready), 32'd0);
        last_rd = 32'd0;
        mem_ack = 1'b1;
        @(negedge clk); res_n = 1'b1; mem_ack = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(db_ready), 32'd0);
        check("post_rst_req", 32'(mem_req), 32'd0);
        run_txn(32'h8000_0000, LEN_W, ACC_X, 32'd0, 32'hCAFE_F00D, 0);

        // Memory that never acknowledges
        @(negedge clk);
        db_addr = 32'h8000_0020; db_memLen = LEN_W; db_accessType = ACC_R;
        @(posedge clk); #1;
        db_accessType = ACC_NONE;
        check("noack_req", 32'(mem_req), 32'd1);
`ifdef MEM_BRIDGE_TIMEOUT_EN
        bad = 0;
        for (int k = 1; k < int'(TB_TIMEOUT); k++) begin
            @(posedge clk); #1;
            if (mem_req !== 1'b1 || db_ready !== 1'b0) bad++;
        end
        check("to_req_window", 32'(bad), 32'd0);
        @(posedge clk); #1;
        check("to_req", 32'(mem_req), 32'd0);
        check("to_ready", 32'(db_ready), 32'd1);
        check("to_error", 32'(db_error), 32'd1);
        check("to_dataIn", db_dataIn, last_rd);
        @(posedge clk); #1;
        check("to_ready_pulse", 32'(db_ready), 32'd0);
`else
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #1;
            if (mem_req !== 1'b1 || db_ready !== 1'b0) bad++;
        end
        check("noack_1000", 32'(bad), 32'd0);
        res_n = 1'b0;
        #3;
        check("noack_rst_req", 32'(mem_req), 32'd0);
        @(negedge clk); res_n = 1'b1;
`endif
        run_txn(32'h8000_0004, LEN_B, ACC_R, 32'd0, 32'h1122_3344, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of ACCESS cycles without mem_ack before a bus error (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port res_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port db_addr, input, 32 bits: CPU byte address.
REQ-005 SHALL have port db_accessType, input, `MEM_ACCESS: NONE, R, W or X (X is handled as R).
REQ-006 SHALL have port db_memLen, input, `MEM_LEN: B, H or W.
REQ-007 SHALL have port db_dataOut, input, 32 bits: CPU write data, right-justified.
REQ-008 SHALL have port db_dataIn, output, 32 bits: read data, right-justified, upper bits zero.
REQ-009 SHALL have port db_ready, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port db_error, output, 1 bit: qualifies db_ready; alignment or bus error.
REQ-011 SHALL have port mem_req, output, 1 bit: memory request, held until mem_ack.
REQ-012 SHALL have port mem_we, output, 1 bit: write strobe.
REQ-013 SHALL have port mem_addr, output, 30 bits: word address, equal to db_addr[31:2].
REQ-014 SHALL have port mem_be, output, 4 bits: byte-lane enables.
REQ-015 SHALL have port mem_wdata, output, 32 bits: lane-replicated write data.
REQ-016 SHALL have port mem_rdata, input, 32 bits: memory read word.
REQ-017 SHALL have port mem_ack, input, 1 bit: completion; mem_rdata is valid in the same cycle.

Function
REQ-018 SHALL implement states IDLE, ACCESS and RESP; all outputs SHALL be registered.
REQ-019 IDLE: when db_accessType != NONE, SHALL capture addr, len, type and data, then go to ACCESS with mem_req=1 in the next cycle.
REQ-020 Misalignment SHALL mean H with addr[0]=1, or W with addr[1:0]!=0. On misalignment IDLE SHALL skip ACCESS and go to RESP with db_error=1 and db_dataIn=0; mem_req SHALL stay 0.
REQ-021 Byte enables SHALL be: B = 4'b0001<<addr[1:0]; H = addr[1] ? 4'b1100 : 4'b0011; W = 4'b1111. This applies to both reads and writes.
REQ-022 mem_wdata SHALL be: B = {4{d[7:0]}}; H = {2{d[15:0]}}; W = d.
REQ-023 Read data SHALL be mem_rdata shifted right by 8*addr[1:0] (B) or 16*addr[1] (H), then zero-extended to 32 bits.
REQ-024 ACCESS: mem_req, mem_we, mem_addr, mem_be and mem_wdata SHALL stay stable until mem_ack. On mem_ack: mem_req=0, db_dataIn is loaded (reads only), go to RESP.
REQ-025 RESP SHALL assert db_ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-026 Latency SHALL be: request visible in cycle N; mem_req high in N+1; with zero-wait mem_ack in N+1, db_ready high in N+2.
REQ-027 db_dataIn SHALL hold its value until the next completed read; after a write it SHALL be unchanged.
REQ-028 Changes on db_* inputs during ACCESS or RESP SHALL be ignored.
REQ-029 mem_ack in IDLE or RESP SHALL be ignored.
REQ-030 db_error SHALL be 0 on every response that is not an error response.

Reset
REQ-031 res_n=0 SHALL immediately force state IDLE, mem_req=0, mem_we=0, db_ready=0, db_error=0, and mem_addr, mem_be, mem_wdata and db_dataIn all to 0.
REQ-032 Reset during ACCESS SHALL abandon the transfer with no db_ready. The first request after reset release SHALL be accepted normally.

Configuration
REQ-033 With MEM_BRIDGE_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ack.
REQ-034 With MEM_BRIDGE_TIMEOUT_EN defined, when the counter reaches TIMEOUT: mem_req=0, go to RESP, db_error=1, db_dataIn unchanged. If mem_ack arrives in that same cycle, the ack SHALL win.
REQ-035 Without MEM_BRIDGE_TIMEOUT_EN, there SHALL be no counter, and ACCESS SHALL wait for mem_ack indefinitely.

Verification
REQ-036 Zero-wait read: LB from 0x80000003 with mem_rdata=0xAABBCCDD -> mem_be=1000; db_dataIn=0x000000AA; db_ready in N+2.
REQ-037 Write: SH of 0x1234 to 0x80000102 with ack after 3 cycles -> mem_we=1, mem_be=1100, mem_wdata=0x12341234, mem_addr=0x20000040, one db_ready pulse, db_error=0.
REQ-038 Misaligned: LW at 0x80000002 -> no mem_req; db_ready=1 and db_error=1 in N+1; db_dataIn=0.
REQ-039 Timeout (macro defined, TIMEOUT=4): never ack -> mem_req drops after 4 cycles; db_error=1 and db_ready=1. Without the macro -> mem_req stays high for 1000 cycles.
REQ-040 Reset mid-ACCESS: res_n=0 while mem_req=1 -> mem_req=0 asynchronously, no db_ready. After release, an X fetch of 0x80000000 completes with the full word.
